// File: rtl/avalon_bus_fabric.sv
// Single-host Avalon-MM fabric: address decode to N slaves, in-order read
// return through an order FIFO, waitrequest timeout and first-error capture.
`timescale 1ns/1ps
module avalon_bus_fabric #(
    parameter int                        NUM_SLAVES      = 10,
    parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE        = '0,
    parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK        = '0,
    parameter int                        MAX_OUTSTANDING = 4,
    parameter int                        TIMEOUT_CYC     = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              h_addr_i,
    input  logic                     h_read_i,
    input  logic                     h_write_i,
    input  logic [31:0]              h_wdata_i,
    input  logic [3:0]               h_byteen_i,
    output logic                     h_waitreq_o,
    output logic [31:0]              h_rdata_o,
    output logic                     h_rdvalid_o,
    output logic                     h_rderr_o,
    output logic [NUM_SLAVES-1:0]    s_chipsel_o,
    output logic [31:0]              s_addr_o,
    output logic                     s_read_o,
    output logic                     s_write_o,
    output logic [31:0]              s_wdata_o,
    output logic [3:0]               s_byteen_o,
    input  logic [NUM_SLAVES-1:0]    s_waitreq_i,
    input  logic [NUM_SLAVES*32-1:0] s_rdata_i,
    input  logic [NUM_SLAVES-1:0]    s_rdvalid_i,
    input  logic                     err_clr_i,
    output logic                     err_valid_o,
    output logic [1:0]               err_code_o,
    output logic [31:0]              err_addr_o
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int TW = $clog2(TIMEOUT_CYC + 2);
    localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_code_t;

    typedef struct packed {
        logic          err;
        logic [IW-1:0] idx;
    } ord_t;

    logic                  mapped;
    logic [IW-1:0]         sel_idx;
    logic [31:0]           sel_mask;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic                  raw_wait;

    logic                  pending, full, rd_block, to_hit, fwd, accept, push, pop, stall;
    logic                  err_ev;
    err_code_t             err_ev_code;

    ord_t                  fifo_q [MAX_OUTSTANDING];
    ord_t                  head, push_entry;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  head_vld;
    logic [31:0]           head_data;

    logic [TW-1:0]         to_cnt_q;
    logic                  err_valid_q;
    err_code_t             err_code_q;
    logic [31:0]           err_addr_q;

    // Lowest-indexed matching slave wins.
    always_comb begin
        mapped     = 1'b0;
        sel_idx    = '0;
        sel_mask   = '0;
        sel_onehot = '0;
        raw_wait   = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!mapped && ((h_addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                mapped        = 1'b1;
                sel_idx       = IW'(i);
                sel_mask      = SLV_MASK[32*i +: 32];
                sel_onehot[i] = 1'b1;
                raw_wait      = s_waitreq_i[i];
            end
        end
    end

    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        head_vld  = 1'b0;
        head_data = '0;
        if (count_q != '0) begin
            if (head.err) begin
                head_vld = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                    if (head.idx == IW'(i)) begin
                        head_vld  = s_rdvalid_i[i];
                        head_data = s_rdata_i[32*i +: 32];
                    end
                end
            end
        end
    end

    assign pop         = head_vld;
    assign h_rdvalid_o = head_vld;
    assign h_rderr_o   = head_vld & head.err;
    assign h_rdata_o   = (head_vld && !head.err) ? head_data : '0;

    // A pop in the same cycle frees the slot, so a read to a full FIFO may still go through.
    always_comb begin
        pending  = h_read_i | h_write_i;
        full     = (count_q == FIFO_FULL);
        rd_block = h_read_i & full & ~pop;
        to_hit   = (TIMEOUT_CYC != 0) && pending && mapped && raw_wait && !rd_block
                   && (to_cnt_q >= TO_LAST);
        h_waitreq_o = pending & (rd_block | (mapped & raw_wait & ~to_hit));
        fwd      = rst_ni & pending & mapped & ~rd_block & ~to_hit;
        accept   = pending & ~h_waitreq_o;
        push     = accept & h_read_i;
        stall    = pending & mapped & h_waitreq_o;
        push_entry.err = ~mapped | to_hit;
        push_entry.idx = sel_idx;
        err_ev      = accept & (~mapped | to_hit);
        err_ev_code = mapped ? ERR_TIMEOUT : ERR_UNMAPPED;
    end

    assign s_chipsel_o = fwd ? sel_onehot : '0;
    assign s_read_o    = fwd & h_read_i;
    assign s_write_o   = fwd & h_write_i;
    assign s_addr_o    = h_addr_i & ~sel_mask;
    assign s_wdata_o   = h_wdata_i;
    assign s_byteen_o  = h_byteen_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (!stall) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    // A clear in the same cycle as a new error still lets the new error in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_addr_q  <= '0;
        end else if (err_ev && (!err_valid_q || err_clr_i)) begin
            err_valid_q <= 1'b1;
            err_code_q  <= err_ev_code;
            err_addr_q  <= h_addr_i;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_code_o  = err_code_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_avalon_bus_fabric.sv
// Directed bench for avalon_bus_fabric; read responses are checked against a
// queue of expected {rderr, rdata} entries filled as reads are issued.
`timescale 1ns/1ps
module tb_avalon_bus_fabric;

    localparam int NS = 10;
    localparam logic [NS*32-1:0] BASES = {
        32'h0001_0000, 32'h0008_0000, 32'h0007_0000, 32'h0006_0000, 32'h0005_0000,
        32'h0040_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASKS = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
        32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic              clk_i;
    logic              rst_ni;
    logic [31:0]       h_addr_i, h_wdata_i;
    logic              h_read_i, h_write_i;
    logic [3:0]        h_byteen_i;
    logic              h_waitreq_o, h_rdvalid_o, h_rderr_o;
    logic [31:0]       h_rdata_o;
    logic [NS-1:0]     s_chipsel_o;
    logic [31:0]       s_addr_o, s_wdata_o;
    logic              s_read_o, s_write_o;
    logic [3:0]        s_byteen_o;
    logic [NS-1:0]     s_waitreq_i, s_rdvalid_i;
    logic [NS*32-1:0]  s_rdata_i;
    logic              err_clr_i, err_valid_o;
    logic [1:0]        err_code_o;
    logic [31:0]       err_addr_o;

    int                checks = 0;
    int                errors = 0;
    logic [32:0]       expq[$];

    avalon_bus_fabric #(
        .NUM_SLAVES(NS), .SLV_BASE(BASES), .SLV_MASK(MASKS),
        .MAX_OUTSTANDING(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h_addr_i(h_addr_i), .h_read_i(h_read_i), .h_write_i(h_write_i),
        .h_wdata_i(h_wdata_i), .h_byteen_i(h_byteen_i), .h_waitreq_o(h_waitreq_o),
        .h_rdata_o(h_rdata_o), .h_rdvalid_o(h_rdvalid_o), .h_rderr_o(h_rderr_o),
        .s_chipsel_o(s_chipsel_o), .s_addr_o(s_addr_o), .s_read_o(s_read_o),
        .s_write_o(s_write_o), .s_wdata_o(s_wdata_o), .s_byteen_o(s_byteen_o),
        .s_waitreq_i(s_waitreq_i), .s_rdata_i(s_rdata_i), .s_rdvalid_i(s_rdvalid_i),
        .err_clr_i(err_clr_i), .err_valid_o(err_valid_o), .err_code_o(err_code_o),
        .err_addr_o(err_addr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic host_idle();
        h_read_i  = 1'b0;
        h_write_i = 1'b0;
    endtask

    task automatic slv_rsp(input int k, input logic [31:0] d);
        s_rdvalid_i            = '0;
        s_rdvalid_i[k]         = 1'b1;
        s_rdata_i[32*k +: 32]  = d;
    endtask

    // Read-return scoreboard
    always @(negedge clk_i) begin : mon
        logic [32:0] e;
        if (h_rdvalid_o === 1'b1) begin
            if (expq.size() == 0) begin
                chk1("rd_unexpected", h_rdvalid_o, 1'b0);
            end else begin
                e = expq.pop_front();
                chk1("rd_err", h_rderr_o, e[32]);
                chk32("rd_data", h_rdata_o, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        host_idle();
        h_addr_i = '0; h_wdata_i = '0; h_byteen_i = '0; err_clr_i = 1'b0;
        s_waitreq_i = '0; s_rdvalid_i = '0;
        for (int k = 0; k < NS; k++) s_rdata_i[32*k +: 32] = 32'hDEAD_0000 | 32'(k);

        // Reset: strobes held low even with a command presented
        h_addr_i = 32'h0040_0008; h_read_i = 1'b1; h_write_i = 1'b1;
        #7;
        chk1("rst_sread", s_read_o, 1'b0);
        chk1("rst_swrite", s_write_o, 1'b0);
        chk32("rst_chipsel", 32'(s_chipsel_o), 32'h0);
        chk1("rst_rdvalid", h_rdvalid_o, 1'b0);
        chk1("rst_errvalid", err_valid_o, 1'b0);
        chk32("rst_errcode", 32'(err_code_o), 32'h0);
        chk32("rst_erraddr", err_addr_o, 32'h0);
        host_idle();
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // Mapped read to slave 4, one waitrequest cycle
        h_addr_i = 32'h0040_0008; h_read_i = 1'b1; s_waitreq_i[4] = 1'b1;
        #1;
        chk32("rd4_chipsel", 32'(s_chipsel_o), 32'h0000_0010);
        chk32("rd4_saddr", s_addr_o, 32'h0000_0008);
        chk1("rd4_sread", s_read_o, 1'b1);
        chk1("rd4_wait", h_waitreq_o, 1'b1);
        tick();
        s_waitreq_i[4] = 1'b0;
        #1;
        chk1("rd4_accept", h_waitreq_o, 1'b0);
        expq.push_back({1'b0, 32'hA5A5_0004});
        tick();
        host_idle();
        s_rdata_i[32*4 +: 32] = 32'hA5A5_0004;
        #1;
        chk1("rd4_novalid", h_rdvalid_o, 1'b0);
        chk32("rd4_rdata_gated", h_rdata_o, 32'h0);
        tick();
        slv_rsp(4, 32'hA5A5_0004);
        tick();
        s_rdvalid_i = '0;

        // Overlapping decode: slaves 1 and 9 both match, slave 1 wins
        h_addr_i = 32'h0001_0004; h_write_i = 1'b1; h_wdata_i = 32'hCAFE_F00D; h_byteen_i = 4'b0110;
        #1;
        chk32("wr_chipsel", 32'(s_chipsel_o), 32'h0000_0002);
        chk32("wr_saddr", s_addr_o, 32'h0000_0004);
        chk1("wr_swrite", s_write_o, 1'b1);
        chk1("wr_sread", s_read_o, 1'b0);
        chk32("wr_wdata", s_wdata_o, 32'hCAFE_F00D);
        chk32("wr_byteen", 32'(s_byteen_o), 32'h6);
        tick();
        host_idle();
        chk1("wr_noerr", err_valid_o, 1'b0);

        // Unmapped read -> ERR returned next cycle, error logged
        h_addr_i = 32'h0300_0000; h_read_i = 1'b1;
        #1;
        chk1("um_wait", h_waitreq_o, 1'b0);
        chk32("um_chipsel", 32'(s_chipsel_o), 32'h0);
        chk1("um_sread", s_read_o, 1'b0);
        expq.push_back({1'b1, 32'h0});
        tick();
        host_idle();
        chk1("um_errvalid", err_valid_o, 1'b1);
        chk32("um_errcode", 32'(err_code_o), 32'h1);
        chk32("um_erraddr", err_addr_o, 32'h0300_0000);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk1("um_clr", err_valid_o, 1'b0);

        // Unmapped write: dropped, logged
        h_addr_i = 32'h0300_0010; h_write_i = 1'b1;
        #1;
        chk1("umw_swrite", s_write_o, 1'b0);
        chk1("umw_wait", h_waitreq_o, 1'b0);
        tick();
        host_idle();
        chk32("umw_errcode", 32'(err_code_o), 32'h1);
        chk32("umw_erraddr", err_addr_o, 32'h0300_0010);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;

        // Four reads to slaves 1,2,1,2 fill the FIFO; slave 2 answers early
        for (int i = 0; i < 4; i++) begin
            h_addr_i = ((i % 2) == 0) ? 32'h0001_0000 + 32'(i * 4) : 32'h0002_0000 + 32'(i * 4);
            h_read_i = 1'b1;
            #1;
            chk1("ord_accept", h_waitreq_o, 1'b0);
            case (i)
                0: expq.push_back({1'b0, 32'h1111_000A});
                1: expq.push_back({1'b0, 32'h2222_000A});
                2: expq.push_back({1'b0, 32'h1111_000B});
                default: expq.push_back({1'b0, 32'h2222_000B});
            endcase
            tick();
        end
        h_addr_i = 32'h0001_0040;
        slv_rsp(2, 32'h2222_000A);
        #1;
        chk1("full_wait", h_waitreq_o, 1'b1);
        chk1("full_sread", s_read_o, 1'b0);
        chk1("nonhead_ignored", h_rdvalid_o, 1'b0);
        tick();
        slv_rsp(1, 32'h1111_000A);
        #1;
        chk1("full_pop_accept", h_waitreq_o, 1'b0);
        chk1("full_pop_sread", s_read_o, 1'b1);
        expq.push_back({1'b0, 32'h1111_000C});
        tick();
        host_idle();
        slv_rsp(2, 32'h2222_000A); tick();
        slv_rsp(1, 32'h1111_000B); tick();
        slv_rsp(2, 32'h2222_000B); tick();
        slv_rsp(1, 32'h1111_000C); tick();
        s_rdvalid_i = '0;
        chk32("ord_drained", 32'(expq.size()), 32'h0);

        // Timeout: slave 3 holds waitrequest
        h_addr_i = 32'h0003_0000; h_read_i = 1'b1; s_waitreq_i[3] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            #1;
            chk1("to_waitreq", h_waitreq_o, (n < 8));
            if (n == 8) begin
                chk1("to_sread", s_read_o, 1'b0);
                expq.push_back({1'b1, 32'h0});
            end
            tick();
        end
        host_idle();
        s_waitreq_i[3] = 1'b0;
        chk1("to_errvalid", err_valid_o, 1'b1);
        chk32("to_errcode", 32'(err_code_o), 32'h2);
        chk32("to_erraddr", err_addr_o, 32'h0003_0000);
        h_addr_i = 32'h0300_0020; h_write_i = 1'b1;
        tick();
        host_idle();
        chk32("second_err_code", 32'(err_code_o), 32'h2);
        chk32("second_err_addr", err_addr_o, 32'h0003_0000);
        h_addr_i = 32'h0300_0040; h_write_i = 1'b1; err_clr_i = 1'b1;
        tick();
        host_idle(); err_clr_i = 1'b0;
        chk1("clr_new_valid", err_valid_o, 1'b1);
        chk32("clr_new_code", 32'(err_code_o), 32'h1);
        chk32("clr_new_addr", err_addr_o, 32'h0300_0040);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk1("clr_only", err_valid_o, 1'b0);

        // Reset with three reads outstanding
        h_addr_i = 32'h0300_0060; h_write_i = 1'b1;
        tick();
        host_idle();
        chk1("pre_rst_err", err_valid_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            h_addr_i = 32'h0005_0000 + 32'(i * 4); h_read_i = 1'b1;
            tick();
        end
        host_idle();
        #2;
        rst_ni = 1'b0;
        #1;
        chk1("mid_rst_errvalid", err_valid_o, 1'b0);
        chk1("mid_rst_rdvalid", h_rdvalid_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        slv_rsp(5, 32'h5555_0001);
        #1;
        chk1("late_rdvalid", h_rdvalid_o, 1'b0);
        tick();
        s_rdvalid_i = '0;
        h_addr_i = 32'h0300_0080; h_read_i = 1'b1;
        #1;
        chk1("post_rst_wait", h_waitreq_o, 1'b0);
        expq.push_back({1'b1, 32'h0});
        tick();
        host_idle();
        for (int n = 0; n < 20 && expq.size() != 0; n++) tick();
        chk32("final_drain", 32'(expq.size()), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
